// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register with valid/ready handshaking and XZR write suppression.
// Define MEM_WB_PIPE_SKID_EN to add a one-entry skid buffer (registered in_ready, two-entry capacity).
module mem_wb_pipe_reg #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_d,
  input  logic [ADDR_W-1:0] reg_write_addr_d,
  input  logic              RegWrite_d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_q,
  output logic [ADDR_W-1:0] reg_write_addr_q,
  output logic              RegWrite_q
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // a producer holding valid keeps its payload stable until that edge.
  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [ADDR_W-1:0] main_addr;
  logic              main_we;
  logic              take_in;
  logic              take_out;

  assign take_in  = in_valid & in_ready;
  assign take_out = main_valid & out_ready;

`ifdef MEM_WB_PIPE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [ADDR_W-1:0] skid_addr;
  logic              skid_we;

  // Only registered state feeds in_ready, so out_ready never reaches the upstream stage.
  assign in_ready = reset & ~skid_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_addr  <= '0;
      main_we    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_addr  <= '0;
      skid_we    <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (take_out) begin
      if (skid_valid) begin
        // take_in is impossible here because in_ready is low while the skid is full.
        main_data  <= skid_data;
        main_addr  <= skid_addr;
        main_we    <= skid_we;
        skid_valid <= 1'b0;
      end else if (take_in) begin
        main_data <= data_d;
        main_addr <= reg_write_addr_d;
        main_we   <= RegWrite_d;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (take_in) begin
      if (main_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= data_d;
        skid_addr  <= reg_write_addr_d;
        skid_we    <= RegWrite_d;
      end else begin
        main_valid <= 1'b1;
        main_data  <= data_d;
        main_addr  <= reg_write_addr_d;
        main_we    <= RegWrite_d;
      end
    end
  end
`else
  assign in_ready = reset & (~main_valid | out_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_addr  <= '0;
      main_we    <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (take_in) begin
      main_valid <= 1'b1;
      main_data  <= data_d;
      main_addr  <= reg_write_addr_d;
      main_we    <= RegWrite_d;
    end else if (take_out) begin
      // Payload is left stale; only the valid bit drops.
      main_valid <= 1'b0;
    end
  end
`endif

  assign out_valid        = main_valid;
  assign data_q           = main_data;
  assign reg_write_addr_q = main_addr;
  assign RegWrite_q       = main_we & main_valid & (main_addr != ZERO_ADDR);

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench for mem_wb_pipe_reg: directed scenarios followed by randomized traffic.
// Follows MEM_WB_PIPE_SKID_EN so capacity and in_ready expectations match the build.
module tb_mem_wb_pipe_reg;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;
  localparam int W        = DATA_W + ADDR_W + 1;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_d;
  logic [ADDR_W-1:0] reg_write_addr_d;
  logic              RegWrite_d;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] reg_write_addr_q;
  logic              RegWrite_q;

  mem_wb_pipe_reg #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .data_d          (data_d),
    .reg_write_addr_d(reg_write_addr_d),
    .RegWrite_d      (RegWrite_d),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .data_q          (data_q),
    .reg_write_addr_q(reg_write_addr_q),
    .RegWrite_q      (RegWrite_q)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ordered queue of accepted entries, bounded by capacity.
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  bit           model_in_ready = 1'b0;
  bit           zero_exp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Driver: inputs change 1 time unit after the rising edge.
  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a,
                       input logic w, input logic ordy);
    @(posedge clk);
    #1;
    reset            = rst;
    flush            = fl;
    in_valid         = iv;
    data_d           = d;
    reg_write_addr_d = a;
    RegWrite_d       = w;
    out_ready        = ordy;
  endtask

  // Issue side: record every entry the model says is accepted this cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset && !flush && in_valid && model_in_ready)
        exp_q.push_back({data_d, reg_write_addr_d, RegWrite_d});
    end
  end

  // Monitor: compares DUT outputs against the head of the expected queue.
  initial begin
    logic [W-1:0]        head;
    logic [ADDR_W-1:0]   h_addr;
    bit                  exp_rdy;
    int                  occ;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #1;
      occ = exp_q.size();
`ifdef MEM_WB_PIPE_SKID_EN
      exp_rdy = reset && (occ < 2);
`else
      exp_rdy = reset && (occ == 0 || out_ready);
`endif
      model_in_ready = exp_rdy;
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      check("out_valid", 64'(out_valid), 64'(occ != 0));
      if (zero_exp) begin
        check("reset_data_q", 64'(data_q), 64'd0);
        check("reset_addr_q", 64'(reg_write_addr_q), 64'd0);
      end
      if (occ != 0) begin
        head   = exp_q[0];
        h_addr = head[ADDR_W:1];
        check("data_q", 64'(data_q), 64'(head[W-1 -: DATA_W]));
        check("reg_write_addr_q", 64'(reg_write_addr_q), 64'(h_addr));
        check("RegWrite_q", 64'(RegWrite_q), 64'(head[0] && (int'(h_addr) != ZERO_REG)));
      end else begin
        check("RegWrite_q_idle", 64'(RegWrite_q), 64'd0);
      end
      if (!reset || flush) exp_q.delete();
      else if (occ != 0 && out_ready) void'(exp_q.pop_front());
      zero_exp = !reset;
    end
  end

  // Stimulus
  initial begin
    reset            = 1'b0;
    flush            = 1'b0;
    in_valid         = 1'b1;
    data_d           = 64'hFFFF;
    reg_write_addr_d = 5'd7;
    RegWrite_d       = 1'b1;
    out_ready        = 1'b0;

    // Reset held with traffic offered, then first entry right after release.
    repeat (3) drive(1'b0, 1'b0, 1'b1, 64'hFFFF, 5'd7, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 64'h1234, 5'd3, 1'b1, 1'b1);
    // Write to the zero register is suppressed.
    drive(1'b1, 1'b0, 1'b1, 64'hAA, 5'd31, 1'b1, 1'b1);
    // Stall with 0x55 held while 0x66 is offered.
    drive(1'b1, 1'b0, 1'b1, 64'h55, 5'd4, 1'b1, 1'b1);
    repeat (4) drive(1'b1, 1'b0, 1'b1, 64'h66, 5'd5, 1'b1, 1'b0);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b1);

    // Back-to-back stream.
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b0, 1'b1, 64'(i), 5'(i), 1'b1, 1'b1);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b1);

    // Flush while stalled, with a new entry offered in the flush cycle.
    drive(1'b1, 1'b0, 1'b1, 64'h88, 5'd6, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 64'h77, 5'd7, 1'b1, 1'b0);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b1);

    // Reset mid-stall with the buffer full.
    drive(1'b1, 1'b0, 1'b1, 64'h99, 5'd8, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 64'hAB, 5'd9, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 64'hCD, 5'd2, 1'b1, 1'b0);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b1);

    // Randomized traffic including the zero register, flushes and occasional resets.
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0));
    repeat (4) drive(1'b1, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b1);

    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_wb_pipe_reg.md
MEM_WB_PIPE_REG -- requirements
Module: mem_wb_pipe_reg

Interface
REQ-001 Parameter DATA_W, default 64, write-back data width in bits.
REQ-002 Parameter ADDR_W, default 5, register-file address width in bits.
REQ-003 Parameter ZERO_REG, default 31, register index hard-wired to zero (XZR); writes to it are suppressed.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled only on rising clk edge.
REQ-006 flush  input  1  synchronous squash of all held entries.
REQ-007 in_valid  input  1  upstream (MEM stage) entry present.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 data_d  input  DATA_W  write-back data.
REQ-010 reg_write_addr_d  input  ADDR_W  destination register.
REQ-011 RegWrite_d  input  1  write-enable control bit.
REQ-012 out_valid  output  1  held entry presented to write-back.
REQ-013 out_ready  input  1  write-back consumes the entry this cycle.
REQ-014 data_q, reg_write_addr_q, RegWrite_q  output  DATA_W/ADDR_W/1  registered entry fields.

Function
REQ-015 Transfer in occurs on a rising edge with in_valid=1 and in_ready=1; transfer out occurs with out_valid=1 and out_ready=1.
REQ-016 Latency is exactly one cycle: an entry accepted at edge N is visible on the outputs after edge N.
REQ-017 When out_valid=1 and out_ready=0, data_q, reg_write_addr_q, RegWrite_q and out_valid hold stable.
REQ-018 RegWrite_q = stored RegWrite AND out_valid AND (reg_write_addr_q != ZERO_REG); data_q and reg_write_addr_q carry stored values unmodified.
REQ-019 A simultaneous transfer in and transfer out replaces the held entry with no bubble; out_valid stays 1.
REQ-020 Transfer out without transfer in clears out_valid on the next edge; data_q and reg_write_addr_q keep their stale values.
REQ-021 flush=1 clears every valid bit on the next edge, discards any entry offered that cycle, and has priority over transfer in and transfer out.
REQ-022 Entries with RegWrite_d=0 are still transferred (valid bubbles for ordering); only RegWrite_q is gated.

Reset
REQ-023 While reset=0 at an edge: out_valid=0, RegWrite_q=0, data_q=0, reg_write_addr_q=0, and all internal valid bits = 0.
REQ-024 in_ready=0 while reset=0; the first acceptance is possible at the first edge with reset=1.
REQ-025 Reset has priority over flush and over all transfers.

Configuration
REQ-026 Macro MEM_WB_PIPE_SKID_EN compiles in a one-entry skid buffer.
REQ-027 Without the macro: in_ready = reset AND (NOT out_valid OR out_ready), combinational; capacity is one entry.
REQ-028 With the macro: in_ready is a registered signal equal to NOT skid_valid (0 during reset), with no combinational path from out_ready; capacity is two entries.
REQ-029 With the macro, an entry accepted while the main entry is held stalled goes to the skid; on the next transfer out the skid moves to the main entry, preserving FIFO order.
REQ-030 With the macro, the flush and reset rules clear the skid as well; REQ-016 latency holds when the skid is empty.

Verification
REQ-031 Reset held low 3 cycles with in_valid=1 and data_d=0xFFFF -> all outputs 0, in_ready=0; release, then data_d=0x1234, addr=3, RegWrite_d=1 -> next cycle data_q=0x1234, RegWrite_q=1.
REQ-032 Accept addr=31, RegWrite_d=1, data=0xAA -> out_valid=1, reg_write_addr_q=31, RegWrite_q=0.
REQ-033 Hold out_ready=0 for 4 cycles after accepting 0x55 -> outputs stable at 0x55; without the macro in_ready=0; with the macro one more entry (0x66) is accepted, in_ready then drops, and release yields 0x55 then 0x66.
REQ-034 Stream 8 back-to-back entries 0..7 with out_ready=1 -> 8 consecutive out_valid cycles, values 0..7 in order, no bubble.
REQ-035 Hold an entry stalled, then flush=1 with in_valid=1 (data 0x77) -> next cycle out_valid=0 and 0x77 is never output.
REQ-036 Assert reset=0 mid-stall with the skid full -> next cycle out_valid=0, RegWrite_q=0, and no stale entry appears after release.
